// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge filter.
// Holds the gradient width rule, the row-priming state type and a saturating clamp.
package sobel_pkg;

    // Priming progress of the window: the first two rows only fill the line buffers.
    // The numeric value doubles as the row counter saturating at 2.
    typedef enum logic [1:0] {
        PRIME0 = 2'd0,
        PRIME1 = 2'd1,
        RUN    = 2'd2
    } rowState_e;

    // Signed gradient width: a 3-tap weighted sum (1,2,1) needs two extra bits,
    // and the difference of two such sums needs one more bit for the sign.
    function automatic int gradWidth(input int pixW);
        return pixW + 3;
    endfunction

    // Clamp an unsigned value to the largest number representable in 'bits' bits.
    function automatic logic [31:0] satU(input logic [31:0] value, input int bits);
        logic [31:0] maxVal;
        maxVal = (32'd1 << bits) - 32'd1;
        return (value > maxVal) ? maxVal : value;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line delay buffer: each enabled cycle returns the pixel written DEPTH
// enabled cycles earlier and stores the new one in its place.
// Contents are deliberately not reset; only the pointer is.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int DEPTH = 640
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [PIX_W-1:0] data_i,
    output logic [PIX_W-1:0] data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;

    assign data_o = mem_q[ptr_q];

    // Next pointer position, wrapping after the last slot of the line.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AW'(1);
        end
    end

    // Pointer register, returned to the line start on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage: overwrite the slot just read with the incoming pixel.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel gradient magnitude over a raster pixel stream with
// valid/ready handshakes on both sides. Two pipeline stages after acceptance.
// Optional edge flag output is built when SOBEL_THRESH_EN is defined.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int SHIFT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
    output logic             out_edge,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_mag
);

    localparam int GW = gradWidth(PIX_W);
    localparam int SW = PIX_W + 2;
    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

    logic             accept;
    logic             produce;
    rowState_e        state_q;
    rowState_e        state_d;
    rowState_e        effState;
    logic [CW-1:0]    colCnt_q;
    logic [CW-1:0]    colCnt_d;
    logic [CW-1:0]    effCol;

    logic [PIX_W-1:0] lb1Out;
    logic [PIX_W-1:0] lb2Out;
    logic [PIX_W-1:0] z1_q, z2_q, z4_q, z5_q, z7_q, z8_q;

    logic [SW-1:0]    gxPos, gxNeg, gyPos, gyNeg;
    logic signed [GW-1:0] gx, gy;
    logic [SW-1:0]    absGx, absGy;

    logic             s1Valid_q;
    logic [SW-1:0]    absGx_q, absGy_q;

    logic [GW-1:0]    magSum;
    logic [GW-1:0]    magShift;
    logic [PIX_W-1:0] magNext;

    logic             out_valid_q;
    logic [PIX_W-1:0] out_mag_q;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;

    // Row/column tracking: in_sof forces the accepted pixel to (0,0); a column
    // wrap advances the priming state, and only RUN rows past column 1 produce output.
    always_comb begin
        effState = state_q;
        effCol   = colCnt_q;
        if (in_sof) begin
            effState = PRIME0;
            effCol   = '0;
        end
        state_d  = state_q;
        colCnt_d = colCnt_q;
        produce  = 1'b0;
        if (accept) begin
            produce = (effState == RUN) && (effCol >= CW'(2));
            state_d = effState;
            if (effCol == LAST_COL) begin
                colCnt_d = '0;
                case (effState)
                    PRIME0:  state_d = PRIME1;
                    PRIME1:  state_d = RUN;
                    default: state_d = RUN;
                endcase
            end else begin
                colCnt_d = effCol + CW'(1);
            end
        end
    end

    // Row state and column counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PRIME0;
            colCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            colCnt_q <= colCnt_d;
        end
    end

    // Line buffers: lb1 yields the pixel one row above, lb2 the one two rows above.
    sobel_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lineBuf1 (
        .clk    (clk),
        .reset  (reset),
        .en_i   (accept),
        .data_i (in_pix),
        .data_o (lb1Out)
    );

    sobel_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lineBuf2 (
        .clk    (clk),
        .reset  (reset),
        .en_i   (accept),
        .data_i (lb1Out),
        .data_o (lb2Out)
    );

    // Window columns shift left on every accepted pixel; the newest column
    // (z3, z6, z9) comes straight from the line buffers and the input.
    always_ff @(posedge clk) begin
        if (accept) begin
            z1_q <= z2_q;
            z2_q <= lb2Out;
            z4_q <= z5_q;
            z5_q <= lb1Out;
            z7_q <= z8_q;
            z8_q <= in_pix;
        end
    end

    // Horizontal and vertical gradients and their absolute values.
    always_comb begin
        gxPos = SW'(lb2Out) + (SW'(lb1Out) << 1) + SW'(in_pix);
        gxNeg = SW'(z1_q)   + (SW'(z4_q)   << 1) + SW'(z7_q);
        gyPos = SW'(z7_q)   + (SW'(z8_q)   << 1) + SW'(in_pix);
        gyNeg = SW'(z1_q)   + (SW'(z2_q)   << 1) + SW'(lb2Out);
        gx    = $signed({1'b0, gxPos}) - $signed({1'b0, gxNeg});
        gy    = $signed({1'b0, gyPos}) - $signed({1'b0, gyNeg});
        absGx = gx[GW-1] ? SW'(-gx) : SW'(gx);
        absGy = gy[GW-1] ? SW'(-gy) : SW'(gy);
    end

    // Stage 1: capture absolute gradients; the stage moves whenever the output can.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            absGx_q   <= '0;
            absGy_q   <= '0;
        end else if (in_ready) begin
            s1Valid_q <= produce;
            if (accept) begin
                absGx_q <= absGx;
                absGy_q <= absGy;
            end
        end
    end

    // Magnitude: sum of absolute gradients, scaled down and clamped to pixel range.
    always_comb begin
        magSum   = {1'b0, absGx_q} + {1'b0, absGy_q};
        magShift = magSum >> SHIFT;
        magNext  = PIX_W'(satU(32'(magShift), PIX_W));
    end

    // Stage 2: output register, frozen while downstream refuses a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
        end else if (in_ready) begin
            out_valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                out_mag_q <= magNext;
            end
        end
    end

`ifdef SOBEL_THRESH_EN
    logic out_edge_q;

    assign out_edge = out_edge_q;

    // Edge flag registered alongside the magnitude it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_edge_q <= 1'b0;
        end else if (in_ready && s1Valid_q) begin
            out_edge_q <= (magNext >= thresh);
        end
    end
`else
    // Edge flag and its comparator are not built in this configuration.
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Testbench for sobel_stream: two instances (SHIFT=3 and SHIFT=0) share one
// stimulus stream and are compared every cycle with a frame-array Sobel model.
// Edge flag checks are included when SOBEL_THRESH_EN is defined.
module tb_sobel_stream;

    localparam int PW = 8;
    localparam int IW = 8;

    typedef struct {
        int mag3;
        int mag0;
        int edgeBit;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_sof;
    logic [PW-1:0] in_pix;
    logic          out_ready;
    logic [PW-1:0] thresh;
    logic          in_ready, in_ready0;
    logic          out_valid, out_valid0;
    logic [PW-1:0] out_mag, out_mag0;
    logic          out_edge, out_edge0;

    int checks = 0;
    int passes = 0;

    exp_t expQ[$];
    int   capQ[$];
    int   cap0Q[$];
    int   capEdgeQ[$];
    int   img[4][IW];
    int   mRow = 0;
    int   mCol = 0;
    int   prevHeld = 0;
    int   heldMag = 0;
    int   stallSeen = 0;
    int   stallCnt = 0;
    int   readyRandom = 0;
    int   idlePct = 0;

    int stepRow[6]  = '{0, 0, 127, 127, 0, 0};
    int stepRow0[6] = '{0, 0, 255, 255, 0, 0};

    always #5 clk = ~clk;

    sobel_stream #(.PIX_W(PW), .IMG_W(IW), .SHIFT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
`ifdef SOBEL_THRESH_EN
        .thresh    (thresh),
        .out_edge  (out_edge),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag)
    );

    sobel_stream #(.PIX_W(PW), .IMG_W(IW), .SHIFT(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
`ifdef SOBEL_THRESH_EN
        .thresh    (thresh),
        .out_edge  (out_edge0),
`endif
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_mag   (out_mag0)
    );

`ifndef SOBEL_THRESH_EN
    assign out_edge  = 1'b0;
    assign out_edge0 = 1'b0;
`endif

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference Sobel on the stored frame rows, straight from the kernel definition.
    function automatic int sobelRef(input int r, input int c, input int sh);
        int z1, z2, z3, z4, z6, z7, z8, z9, gx, gy, m;
        z1 = img[(r - 2) % 4][c - 2]; z2 = img[(r - 2) % 4][c - 1]; z3 = img[(r - 2) % 4][c];
        z4 = img[(r - 1) % 4][c - 2];                                z6 = img[(r - 1) % 4][c];
        z7 = img[r % 4][c - 2];       z8 = img[r % 4][c - 1];       z9 = img[r % 4][c];
        gx = (z3 + 2 * z6 + z9) - (z1 + 2 * z4 + z7);
        gy = (z7 + 2 * z8 + z9) - (z1 + 2 * z2 + z3);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = (gx + gy) >> sh;
        return (m > 255) ? 255 : m;
    endfunction

    task automatic modelAccept(input int pix, input bit sof);
        exp_t e;
        if (sof) begin
            mRow = 0;
            mCol = 0;
        end
        img[mRow % 4][mCol] = pix;
        if (mRow >= 2 && mCol >= 2) begin
            e.mag3    = sobelRef(mRow, mCol, 3);
            e.mag0    = sobelRef(mRow, mCol, 0);
            e.edgeBit = (e.mag3 >= int'(thresh)) ? 1 : 0;
            expQ.push_back(e);
        end
        mCol++;
        if (mCol == IW) begin
            mCol = 0;
            mRow++;
        end
    endtask

    // Compare process: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            expQ.delete();
            mRow = 0;
            mCol = 0;
            prevHeld = 0;
        end else begin
            checkOutput("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
            checkOutput("in_ready_sh0", in_ready0, (!out_valid || out_ready) ? 1 : 0);
            if (prevHeld != 0 && out_valid) begin
                checkOutput("hold_mag", out_mag, heldMag);
            end
            prevHeld = (out_valid && !out_ready) ? 1 : 0;
            heldMag  = out_mag;
            if (prevHeld != 0) stallSeen++;
            if (out_valid && out_ready) begin
                checkOutput("result_expected", (expQ.size() > 0) ? 1 : 0, 1);
                checkOutput("valid_sh0", out_valid0, 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("out_mag", out_mag, e.mag3);
                    checkOutput("out_mag_sh0", out_mag0, e.mag0);
`ifdef SOBEL_THRESH_EN
                    checkOutput("out_edge", out_edge, e.edgeBit);
`endif
                end
                capQ.push_back(out_mag);
                cap0Q.push_back(out_mag0);
                capEdgeQ.push_back(out_edge);
            end
            if (in_valid && in_ready) begin
                modelAccept(in_pix, in_sof);
            end
        end
    end

    // Downstream ready: forced low during a requested stall, else random or always high.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stallCnt > 0) begin
                out_ready = 1'b0;
                stallCnt--;
            end else if (readyRandom != 0) begin
                out_ready = ($urandom_range(99) < 70);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input int pix, input bit sof);
        int  n;
        bit  got;
        while (int'($urandom_range(99)) < idlePct) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pix   = PW'(pix);
        in_sof   = sof;
        n   = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 200);
        if (!got) checkOutput("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // kind 0: constant 100, 1: step at column 4, 2: random pixels.
    task automatic sendFrame(input int kind, input int rows, input int lastCols, input bit doStall);
        int pix;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < ((r == rows - 1) ? lastCols : IW); c++) begin
                case (kind)
                    0:       pix = 100;
                    1:       pix = (c >= 4) ? 255 : 0;
                    default: pix = int'($urandom_range(255));
                endcase
                applyStimulus(pix, (r == 0 && c == 0));
                if (doStall && r == 2 && c == 4) stallCnt = 5;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearCapture();
        capQ.delete();
        cap0Q.delete();
        capEdgeQ.delete();
    endtask

    // Pin captured results against the hand-derived step-image pattern.
    task automatic checkCapture(input int expCount, input int split);
        int idx;
        checkOutput("result_count", capQ.size(), expCount);
        for (int i = 0; i < capQ.size() && i < expCount; i++) begin
            idx = (i < split) ? i : i - split;
            checkOutput("step_mag", capQ[i], stepRow[idx % 6]);
            checkOutput("step_mag_sh0", cap0Q[i], stepRow0[idx % 6]);
`ifdef SOBEL_THRESH_EN
            checkOutput("step_edge", capEdgeQ[i], (stepRow[idx % 6] == 127) ? 1 : 0);
`endif
        end
    endtask

    initial begin
        int rows;
        int lastCols;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pix   = '0;
        thresh   = PW'(100);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_mag", out_mag, 0);
        @(posedge clk);
        #1;

        // Constant image: 12 results, all zero.
        clearCapture();
        sendFrame(0, 4, IW, 1'b0);
        idle(10);
        checkOutput("const_count", capQ.size(), 12);
        for (int i = 0; i < capQ.size(); i++) checkOutput("const_mag", capQ[i], 0);

        // Step image, no stall, then with a 5-cycle downstream stall mid-row.
        clearCapture();
        sendFrame(1, 4, IW, 1'b0);
        idle(10);
        checkCapture(12, 0);
        clearCapture();
        stallSeen = 0;
        sendFrame(1, 4, IW, 1'b1);
        idle(10);
        checkCapture(12, 0);
        checkOutput("stall_seen", (stallSeen > 0) ? 1 : 0, 1);

        // Restart with in_sof at column 5 of row 3.
        clearCapture();
        sendFrame(1, 4, 5, 1'b0);
        sendFrame(1, 4, IW, 1'b0);
        idle(10);
        checkCapture(21, 9);

        // Reset mid-row discards everything in flight.
        clearCapture();
        sendFrame(1, 4, 4, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_out_mag", out_mag, 0);
        checkOutput("midreset_out_edge", out_edge, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clearCapture();
        idle(4);
        checkOutput("post_reset_silent", capQ.size(), 0);
        sendFrame(1, 4, IW, 1'b0);
        idle(10);
        checkCapture(12, 0);

        // Random frames with gaps, random backpressure and early restarts.
        readyRandom = 1;
        idlePct     = 20;
        for (int f = 0; f < 8; f++) begin
            rows     = int'($urandom_range(3, 6));
            lastCols = ($urandom_range(3) == 0) ? int'($urandom_range(1, IW - 1)) : IW;
            sendFrame(2, rows, lastCols, 1'b0);
        end
        readyRandom = 0;
        idlePct     = 0;
        idle(20);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
